hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
// - Hazard/forwarding controller for the 5-stage pipeline; drives the six bypass selects of the EX-stage operand muxes.
// - Tracks destination registers of the instructions in EX, MEM and WB.
// - Resolves RAW hazards by forwarding; issues a one-cycle load-use stall when forwarding cannot cover the hazard.
// - Bypass selects are computed at decode and registered, so they are valid for the whole cycle the instruction is in EX.
// PARAMETERS
// - REG_AW   5   register-address width
// - CNT_W    16  width of stall_count
// PORTS
// - clock               in   1      system clock; all state updates on rising edge
// - reset               in   1      synchronous, active-high
// - id_valid            in   1      ID holds a real instruction
// - id_rs, id_rt        in   REG_AW source registers of the ID instruction
// - id_uses_rs/rt       in   1      ID instruction actually reads rs / rt
// - id_dest             in   REG_AW destination register of the ID instruction
// - id_regwrite         in   1      ID instruction writes id_dest
// - id_is_load          in   1      ID instruction is a load (LW)
// - flush               in   1      branch taken: kill the ID instruction this cycle
// - stall               out  1      hold PC and IF/ID; insert bubble into ID/EX (combinational)
// - bypassAfromMEM      out  1      EX operand A from EXMEMALUOut (registered)
// - bypassAfromALUinWB  out  1      EX operand A from MEMWBValue, ALU producer (registered)
// - bypassAfromLWinWB   out  1      EX operand A from MEMWBValue, load producer (registered)
// - bypassB*            out  1      the same three selects for operand B
// - stall_count         out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
// - Stage slots EX, MEM, WB each hold {valid, dest, regwrite, is_load}.
//   - A slot is "producing" iff valid && regwrite && dest != 0.
// - Slot advance every cycle: WB <= MEM; MEM <= EX.
//   - EX <= ID fields, except EX <= bubble (valid=0) when id_valid=0, stall=1 or flush=1.
// - stall = id_valid & ~flush & EX producing & EX.is_load &
//   ((id_uses_rs & id_rs==EX.dest) | (id_uses_rt & id_rt==EX.dest)).
//   - Combinational, asserted exactly 1 cycle per load-use pair.
//   - On the next cycle the load is in MEM, so stall is 0.
// - Bypass selection for operand A, evaluated at ID with id_uses_rs & id_rs!=0 (operand B is identical using rt):
//   - Priority 1: EX producing & ~EX.is_load & id_rs==EX.dest -> next A sel = fromMEM.
//   - Priority 2: else, MEM producing & id_rs==MEM.dest -> next A sel = fromLWinWB if MEM.is_load, else fromALUinWB.
//   - Otherwise: all A selects 0 (operand taken from IDEXA).
//   - Selects load into output registers on the edge the instruction enters EX.
//   - Selects are cleared when a bubble is inserted (stall, flush, or id_valid=0).
//   - The three A selects are one-hot-or-zero; likewise the three B selects.
// - WB-slot matches are not forwarded: the register file writes before reading.
// - Register 0 is never forwarded and never causes a stall.
// - flush has priority over stall: stall is forced to 0 when flush=1.
// - stall_count increments by 1 on each cycle with stall=1 and saturates at 2^CNT_W-1.
// - Reset, also mid-operation, takes effect on the next edge:
//   - all slots invalid; all bypass outputs 0; stall_count 0.
//   - stall is 0 from the first cycle after reset.
// TESTING
// - add r3 then add r4,r3,r3 -> next cycle bypassAfromMEM=1 and bypassBfromMEM=1; all other selects 0.
// - add r3, nop, sub r5,r3,r1 -> sub in EX: bypassAfromALUinWB=1, bypassB*=0.
// - lw r2 then add r6,r2,r7:
//   - stall=1 for exactly one cycle; stall_count 0->1.
//   - the add enters EX one cycle late with bypassAfromLWinWB=1.
// - add r3 then add r3 then or r8,r3,r0 -> MEM wins: bypassAfromMEM=1, fromALUinWB=0.
// - Writes to r0, including lw r0 followed by use of r0 -> no stall, no bypass.
// - lw r2 then dependent instruction with flush=1 -> stall=0, bubble enters EX, selects 0.
// - reset asserted while stall is active -> next cycle all outputs 0 and stall_count=0.
// - 2^CNT_W+3 back-to-back load-use pairs -> stall_count holds at 2^CNT_W-1.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall and EX-operand bypass control for a 5-stage pipeline.
// Tracks producers in EX and MEM and registers the bypass selects as an instruction enters EX.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              bypassAfromMEM,
  output logic              bypassAfromALUinWB,
  output logic              bypassAfromLWinWB,
  output logic              bypassBfromMEM,
  output logic              bypassBfromALUinWB,
  output logic              bypassBfromLWinWB,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              is_load;
  } slot_t;

  slot_t ex_reg, ex_next, mem_reg;
  logic  ex_prod, mem_prod, ex_src_hit, stall_int, issue;
  logic [CNT_W-1:0] stall_count_reg;

  assign ex_prod  = ex_reg.valid & ex_reg.regwrite & (ex_reg.dest != '0);
  assign mem_prod = mem_reg.valid & mem_reg.regwrite & (mem_reg.dest != '0);

  // A matching dest in EX is already nonzero, so r0 can never stall.
  assign ex_src_hit = (id_uses_rs & (id_rs == ex_reg.dest)) |
                      (id_uses_rt & (id_rt == ex_reg.dest));
  assign stall_int  = id_valid & ~flush & ex_prod & ex_reg.is_load & ex_src_hit;
  assign issue      = id_valid & ~stall_int & ~flush;
  assign stall      = stall_int;

  always_comb begin
    ex_next = '0;
    if (issue) begin
      ex_next.valid    = 1'b1;
      ex_next.dest     = id_dest;
      ex_next.regwrite = id_regwrite;
      ex_next.is_load  = id_is_load;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_reg  <= '0;
      mem_reg <= '0;
    end else begin
      ex_reg  <= ex_next;
      mem_reg <= ex_reg;
    end
  end

  // Operand 0 is A (rs), operand 1 is B (rt); sel bits are {lw_in_wb, alu_in_wb, from_mem}.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [REG_AW-1:0] src;
      logic              uses;
      logic [2:0]        sel_next, sel_reg;

      assign src  = (gi == 0) ? id_rs : id_rt;
      assign uses = (gi == 0) ? id_uses_rs : id_uses_rt;

      always_comb begin
        sel_next = '0;
        if (issue && uses && (src != '0)) begin
          if (ex_prod && !ex_reg.is_load && (src == ex_reg.dest)) begin
            sel_next[0] = 1'b1;
          end else if (mem_prod && (src == mem_reg.dest)) begin
            if (mem_reg.is_load) sel_next[2] = 1'b1;
            else                 sel_next[1] = 1'b1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) sel_reg <= '0;
        else       sel_reg <= sel_next;
      end
    end
  endgenerate

  assign bypassAfromMEM     = g_opnd[0].sel_reg[0];
  assign bypassAfromALUinWB = g_opnd[0].sel_reg[1];
  assign bypassAfromLWinWB  = g_opnd[0].sel_reg[2];
  assign bypassBfromMEM     = g_opnd[1].sel_reg[0];
  assign bypassBfromALUinWB = g_opnd[1].sel_reg[1];
  assign bypassBfromLWinWB  = g_opnd[1].sel_reg[2];

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (stall_int && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: driver pushes expectations from an instruction-history model,
// monitor pops one entry per cycle and compares stall, both select groups and stall_count.
module tb_hazard_forward_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_is_load, flush;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          stall;
  logic          bAm, bAa, bAl, bBm, bBa, bBl;
  logic [CW-1:0] stall_count;

  hazard_forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .flush(flush), .stall(stall),
    .bypassAfromMEM(bAm), .bypassAfromALUinWB(bAa), .bypassAfromLWinWB(bAl),
    .bypassBfromMEM(bBm), .bypassBfromALUinWB(bBa), .bypassBfromLWinWB(bBl),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt, dest;
    bit       urs, urt, rw, ld;
  } ins_t;

  typedef struct {
    bit       chk_stall;
    bit       exp_stall;
    bit [2:0] exp_a;   // {lw_in_wb, alu_in_wb, from_mem}
    bit [2:0] exp_b;
    int       exp_cnt;
  } exp_t;

  exp_t q[$];
  ins_t hist[$];       // instructions that entered EX, most recent last
  int   m_cnt = 0;
  bit   model_known = 0;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  function automatic ins_t bubble();
    ins_t x;
    x = '{v:0, rs:0, rt:0, dest:0, urs:0, urt:0, rw:0, ld:0};
    return x;
  endfunction

  function automatic ins_t alu(int d, int s, int t);
    ins_t x;
    x = '{v:1, rs:s[4:0], rt:t[4:0], dest:d[4:0], urs:1, urt:1, rw:1, ld:0};
    return x;
  endfunction

  function automatic ins_t lw(int d, int base);
    ins_t x;
    x = '{v:1, rs:base[4:0], rt:0, dest:d[4:0], urs:1, urt:0, rw:1, ld:1};
    return x;
  endfunction

  function automatic bit writes(ins_t x);
    return x.v && x.rw && (x.dest != 0);
  endfunction

  // Where an operand comes from, given the producers one and two instructions ahead.
  function automatic bit [2:0] pick(bit [4:0] src, bit use_it, ins_t e, ins_t m);
    if (!use_it || src == 0) return 3'b000;
    if (writes(e) && !e.ld && e.dest == src) return 3'b001;
    if (writes(m) && m.dest == src) return m.ld ? 3'b100 : 3'b010;
    return 3'b000;
  endfunction

  task automatic step(input ins_t i, input bit fl, input bit rst, output bit st);
    exp_t  x;
    ins_t  e, m;
    bit    go;
    @(negedge clock);
    reset = rst; flush = fl;
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_dest = i.dest;
    id_uses_rs = i.urs; id_uses_rt = i.urt; id_regwrite = i.rw; id_is_load = i.ld;
    e = hist[hist.size()-1];
    m = hist[hist.size()-2];
    st = i.v && !fl && writes(e) && e.ld &&
         ((i.urs && i.rs == e.dest) || (i.urt && i.rt == e.dest));
    go = i.v && !st && !fl;
    x.chk_stall = model_known;
    x.exp_stall = st;
    if (rst) begin
      x.exp_a = 0; x.exp_b = 0; m_cnt = 0;
      hist.delete(); hist.push_back(bubble()); hist.push_back(bubble());
      model_known = 1;
    end else begin
      x.exp_a = go ? pick(i.rs, i.urs, e, m) : 3'b000;
      x.exp_b = go ? pick(i.rt, i.urt, e, m) : 3'b000;
      if (st && m_cnt < MAXC) m_cnt++;
      hist.push_back(go ? i : bubble());
      if (hist.size() > 4) void'(hist.pop_front());
    end
    x.exp_cnt = m_cnt;
    q.push_back(x);
  endtask

  // Issue one instruction, re-presenting it while the model says it is stalled.
  task automatic run(input ins_t i, input bit fl);
    bit st;
    int n = 0;
    do begin
      step(i, fl, 1'b0, st);
      n++;
    end while (st && n < 4);
    if (st) begin
      checks++; errors++;
      $display("FAIL stall_bound: still stalled after %0d cycles, required release", n);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      #4;
      if (q.size() != 0) begin
        x = q.pop_front();
        if (x.chk_stall) begin
          checks++;
          if (stall !== x.exp_stall) begin
            errors++;
            $display("FAIL stall: txn %0d got %0b required %0b", txn, stall, x.exp_stall);
          end
        end
        @(posedge clock);
        #1;
        checks += 3;
        if ({bAl, bAa, bAm} !== x.exp_a) begin
          errors++;
          $display("FAIL selA: txn %0d got %03b required %03b", txn, {bAl, bAa, bAm}, x.exp_a);
        end
        if ({bBl, bBa, bBm} !== x.exp_b) begin
          errors++;
          $display("FAIL selB: txn %0d got %03b required %03b", txn, {bBl, bBa, bBm}, x.exp_b);
        end
        if (int'(stall_count) != x.exp_cnt) begin
          errors++;
          $display("FAIL stall_count: txn %0d got %0d required %0d", txn, stall_count, x.exp_cnt);
        end
        $display("txn %0d stall=%0b A=%03b B=%03b cnt=%0d", txn, stall,
                 {bAl, bAa, bAm}, {bBl, bBa, bBm}, stall_count);
        txn++;
      end
    end
  end

  initial begin : driver
    bit   st;
    ins_t r;
    reset = 1; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_regwrite = 0; id_is_load = 0;
    hist.push_back(bubble()); hist.push_back(bubble());
    step(bubble(), 0, 1, st);
    step(bubble(), 0, 1, st);

    // EX forwarding on both operands
    run(alu(3, 1, 2), 0); run(alu(4, 3, 3), 0);
    // MEM producer, ALU
    run(alu(3, 1, 2), 0); run(bubble(), 0); run(alu(5, 3, 1), 0);
    // load-use: one stall, then from load in WB
    run(lw(2, 1), 0); run(alu(6, 2, 7), 0);
    // most recent producer wins
    run(alu(3, 1, 2), 0); run(alu(3, 4, 5), 0); run(alu(8, 3, 0), 0);
    // r0 never forwards or stalls
    run(alu(0, 1, 2), 0); run(alu(9, 0, 0), 0);
    run(lw(0, 1), 0); run(alu(9, 0, 0), 0); run(alu(10, 0, 0), 0);
    // flush beats load-use stall
    run(lw(2, 1), 0); run(alu(6, 2, 7), 1); run(bubble(), 0);
    // reset while stall is active
    run(lw(2, 1), 0); step(alu(6, 2, 7), 0, 1, st); run(alu(6, 2, 7), 0);
    run(bubble(), 0);

    for (int k = 0; k < 300; k++) begin
      r.v    = ($urandom_range(7) != 0);
      r.rs   = 5'($urandom_range(3));
      r.rt   = 5'($urandom_range(3));
      r.dest = 5'($urandom_range(3));
      r.urs  = 1'($urandom_range(1));
      r.urt  = 1'($urandom_range(1));
      r.rw   = ($urandom_range(3) != 0);
      r.ld   = r.rw && ($urandom_range(2) == 0);
      run(r, ($urandom_range(9) == 0));
    end

    // saturation of the stall counter
    step(bubble(), 0, 1, st);
    for (int k = 0; k < (1 << CW) + 3; k++) begin
      run(lw(2, 1), 0); run(alu(6, 2, 7), 0);
    end
    run(bubble(), 0);
    @(posedge clock); #3;
    checks++;
    if (int'(stall_count) != MAXC) begin
      errors++;
      $display("FAIL saturate: got %0d required %0d", stall_count, MAXC);
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
